// File: rtl/alu_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_share_arbiter                                             |
// | Purpose  : Round-robin sharing of one external combinational ALU among   |
// |            NREQ requesters. One operation is in flight at a time; the    |
// |            result comes back tagged with the owning requester's index.   |
// | Ports    : clk, rst_n            - clock, async active-low reset         |
// |            req_valid/req_ready   - per-requester issue handshake         |
// |            req_src1/src2/op      - flattened per-requester operands      |
// |            alu_src1/src2/op      - registered operands to the ALU        |
// |            alu_result            - combinational ALU output              |
// |            resp_valid/resp_ready - result handshake                      |
// |            resp_id/data/err      - tag, result, illegal-opcode flag      |
// |            busy                  - FSM not idle                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module alu_share_arbiter #(
  parameter int              DATA_W = 32,
  parameter int              OP_W   = 5,
  parameter int              NREQ   = 4,
  parameter int              ID_W   = 2,
  parameter logic [OP_W-1:0] MAX_OP = 5'b10000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_src1,
  input  logic [NREQ*DATA_W-1:0] req_src2,
  input  logic [NREQ*OP_W-1:0]   req_op,
  output logic [DATA_W-1:0]      alu_src1,
  output logic [DATA_W-1:0]      alu_src2,
  output logic [OP_W-1:0]        alu_op,
  input  logic [DATA_W-1:0]      alu_result,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [DATA_W-1:0]      resp_data,
  output logic                   resp_err,
  output logic                   busy
);

  // Requester slots are padded up to a power of two so that every ID_W-bit
  // index lands on a real (possibly always-idle) slot.
  localparam int c_NSLOT = 1 << ID_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_tag;

  logic [c_NSLOT-1:0] w_valid_ext;
  logic [DATA_W-1:0]  w_src1 [c_NSLOT];
  logic [DATA_W-1:0]  w_src2 [c_NSLOT];
  logic [OP_W-1:0]    w_op   [c_NSLOT];

  logic [ID_W:0]     w_scan;
  logic [ID_W-1:0]   w_sel;
  logic              w_found;
  logic [ID_W-1:0]   w_ptr_next;
  logic [NREQ-1:0]   w_grant;
  logic              w_take;

  // Unpack the flattened request buses into per-slot views.
  generate
    for (genvar g = 0; g < c_NSLOT; g++) begin : g_slot
      if (g < NREQ) begin : g_live
        assign w_valid_ext[g] = req_valid[g];
        assign w_src1[g]      = req_src1[g*DATA_W +: DATA_W];
        assign w_src2[g]      = req_src2[g*DATA_W +: DATA_W];
        assign w_op[g]        = req_op[g*OP_W +: OP_W];
      end else begin : g_pad
        assign w_valid_ext[g] = 1'b0;
        assign w_src1[g]      = '0;
        assign w_src2[g]      = '0;
        assign w_op[g]        = '0;
      end
    end
  endgenerate

  // Round-robin pick: scan ptr, ptr+1, ... (mod NREQ). The loop runs from the
  // far end back towards ptr so the candidate closest to ptr is written last
  // and therefore wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_scan  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_scan = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_scan >= (ID_W+1)'(NREQ)) begin
        w_scan = w_scan - (ID_W+1)'(NREQ);
      end
      if (w_valid_ext[w_scan[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_scan[ID_W-1:0];
      end
    end
  end

  assign w_ptr_next = (w_sel == ID_W'(NREQ - 1)) ? '0 : w_sel + ID_W'(1);
  assign w_grant    = w_found ? (NREQ'(1) << w_sel) : '0;

  // Grants only exist in IDLE; the reset term keeps req_ready low while the
  // block is held in reset even though the grant logic is combinational.
  assign w_take     = rst_n && (r_state == S_IDLE) && w_found;
  assign req_ready  = w_take ? w_grant : '0;

  assign busy       = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_tag      <= '0;
      alu_src1   <= '0;
      alu_src2   <= '0;
      alu_op     <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            alu_src1 <= w_src1[w_sel];
            alu_src2 <= w_src2[w_sel];
            alu_op   <= w_op[w_sel];
            r_tag    <= w_sel;
            r_ptr    <= w_ptr_next;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          // alu_* were registered last cycle, so alu_result is settled now.
          resp_valid <= 1'b1;
          resp_id    <= r_tag;
          if (alu_op > MAX_OP) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
          end else begin
            resp_data <= alu_result;
            resp_err  <= 1'b0;
          end
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_share_arbiter                                          |
// | Purpose  : Self-checking bench for alu_share_arbiter. A transaction-     |
// |            level model predicts grants and results into a queue; a      |
// |            separate monitor compares every presented response.          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_alu_share_arbiter;

  localparam int              DATA_W = 32;
  localparam int              OP_W   = 5;
  localparam int              NREQ   = 4;
  localparam int              ID_W   = 2;
  localparam logic [OP_W-1:0] MAX_OP = 5'b10000;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*DATA_W-1:0] req_src1;
  logic [NREQ*DATA_W-1:0] req_src2;
  logic [NREQ*OP_W-1:0]   req_op;
  logic [DATA_W-1:0]      alu_src1;
  logic [DATA_W-1:0]      alu_src2;
  logic [OP_W-1:0]        alu_op;
  logic [DATA_W-1:0]      alu_result;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [ID_W-1:0]        resp_id;
  logic [DATA_W-1:0]      resp_data;
  logic                   resp_err;
  logic                   busy;

  always #5 clk = ~clk;

  alu_share_arbiter #(
    .DATA_W(DATA_W), .OP_W(OP_W), .NREQ(NREQ), .ID_W(ID_W), .MAX_OP(MAX_OP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2), .req_op(req_op),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_op(alu_op),
    .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
    .busy(busy)
  );

  // Reference ALU: also stands in for the external ALU instance.
  function automatic logic [DATA_W-1:0] alu_ref(input logic [OP_W-1:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      5'd10:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd16:   return {b[15:0], 16'h0000};
      default: return (a + b) ^ {27'd0, op} ^ 32'hA5A5_0000;
    endcase
  endfunction

  always_comb alu_result = alu_ref(alu_op, alu_src1, alu_src2);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic              err;
  } resp_t;

  resp_t exp_q[$];
  resp_t log_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  int    m_state = 0;   // 0 idle, 1 executing, 2 holding a response
  int    m_ptr   = 0;
  int    rr_mode = 1;   // 0 hold low, 1 hold high, 2 random
  logic [NREQ-1:0] hs_seen = '0;

  logic              pend_v  [NREQ];
  logic [DATA_W-1:0] pend_s1 [NREQ];
  logic [DATA_W-1:0] pend_s2 [NREQ];
  logic [OP_W-1:0]   pend_op [NREQ];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired, expected event did not occur", name);
  endtask

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]                    = pend_v[i];
      req_src1[i*DATA_W +: DATA_W]    = pend_s1[i];
      req_src2[i*DATA_W +: DATA_W]    = pend_s2[i];
      req_op[i*OP_W +: OP_W]          = pend_op[i];
    end
  endtask

  task automatic issue(input int i, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] b, input logic [OP_W-1:0] op);
    pend_v[i]  = 1'b1;
    pend_s1[i] = a;
    pend_s2[i] = b;
    pend_op[i] = op;
    apply();
  endtask

  // One clock: requesters that saw req_ready before this edge drop their
  // request; inputs change only 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (hs_seen[i]) pend_v[i] = 1'b0;
    if (rr_mode == 1)      resp_ready = 1'b1;
    else if (rr_mode == 0) resp_ready = 1'b0;
    else                   resp_ready = 1'($urandom_range(0, 1));
    apply();
  endtask

  function automatic bit any_pend();
    for (int i = 0; i < NREQ; i++) if (pend_v[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input string tag);
    for (int n = 0; n < 300; n++) begin
      if (!any_pend() && m_state == 0 && exp_q.size() == 0) return;
      step();
    end
    bound_fail({"drain_", tag});
  endtask

  // Reference model: decides grants from the requests the bench is driving
  // and the round-robin rule, and pushes the expected response.
  always @(negedge clk) begin
    int              win;
    int              c;
    logic [NREQ-1:0] er;
    resp_t           e;
    hs_seen = req_valid & req_ready;
    if (!rst_n) begin
      m_state = 0;
      m_ptr   = 0;
      exp_q.delete();
    end else begin
      case (m_state)
        0: begin
          win = -1;
          for (int k = 0; k < NREQ; k++) begin
            c = (m_ptr + k) % NREQ;
            if (win < 0 && req_valid[c]) win = c;
          end
          er = (win >= 0) ? (NREQ'(1) << win) : '0;
          chk("req_ready_idle", 64'(req_ready), 64'(er));
          chk("busy_idle", 64'(busy), 64'd0);
          chk("resp_valid_idle", 64'(resp_valid), 64'd0);
          if (win >= 0) begin
            e.id   = ID_W'(win);
            e.err  = (pend_op[win] > MAX_OP);
            e.data = e.err ? '0 : alu_ref(pend_op[win], pend_s1[win], pend_s2[win]);
            exp_q.push_back(e);
            m_ptr   = (win + 1) % NREQ;
            m_state = 1;
          end
        end
        1: begin
          chk("req_ready_exec", 64'(req_ready), 64'd0);
          chk("busy_exec", 64'(busy), 64'd1);
          chk("resp_valid_exec", 64'(resp_valid), 64'd0);
          m_state = 2;
        end
        default: begin
          chk("req_ready_resp", 64'(req_ready), 64'd0);
          chk("busy_resp", 64'(busy), 64'd1);
          chk("resp_valid_resp", 64'(resp_valid), 64'd1);
          if (resp_ready) m_state = 0;
        end
      endcase
    end
  end

  // Monitor: every cycle a response is presented it must match the oldest
  // prediction; it is retired when the consumer accepts it.
  always @(negedge clk) begin
    resp_t a;
    if (rst_n && resp_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL resp_unexpected: got id %0d data %0h, expected no response",
                 resp_id, resp_data);
      end else begin
        chk("resp_id", 64'(resp_id), 64'(exp_q[0].id));
        chk("resp_data", 64'(resp_data), 64'(exp_q[0].data));
        chk("resp_err", 64'(resp_err), 64'(exp_q[0].err));
        if (resp_ready) begin
          a.id   = resp_id;
          a.data = resp_data;
          a.err  = resp_err;
          log_q.push_back(a);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int exp_ids4 [5];
    int exp_dat4 [5];
    bit seen;
    exp_ids4 = '{0, 1, 2, 3, 0};
    exp_dat4 = '{2, 8, 10, 2, 7};
    for (int i = 0; i < NREQ; i++) begin
      pend_v[i] = 1'b0; pend_s1[i] = '0; pend_s2[i] = '0; pend_op[i] = '0;
    end
    req_valid  = '0;
    req_src1   = '0;
    req_src2   = '0;
    req_op     = '0;
    resp_ready = 1'b1;
    apply();

    // Reset state, with a request already pending.
    issue(0, 32'd1, 32'd2, 5'd0);
    step(); step();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_alu", {alu_src1, alu_src2} | 64'(alu_op), 64'd0);
    chk("rst_resp", {resp_data, 32'(resp_id)} | 64'(resp_err), 64'd0);
    pend_v[0] = 1'b0;
    apply();
    step();
    rst_n = 1'b1;

    // Single request: 10 + 8.
    log_q.delete();
    issue(0, 32'd10, 32'd8, 5'd0);
    drain("single");
    chk("single_count", 64'(log_q.size()), 64'd1);
    if (log_q.size() == 1) begin
      chk("single_data", 64'(log_q[0].data), 64'd18);
      chk("single_id", 64'(log_q[0].id), 64'd0);
    end

    // Reset during EXEC: response discarded, pointer cleared.
    issue(2, 32'd1, 32'd2, 5'd0);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      step();
      if (!pend_v[2]) seen = 1'b1;
    end
    if (!seen) bound_fail("exec_grant");
    chk("busy_before_reset", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_alu_src1", 64'(alu_src1), 64'd0);
    chk("async_rst_resp_valid", 64'(resp_valid), 64'd0);
    step(); step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("no_resp_after_reset", 64'(resp_valid), 64'd0);

    // All four at once from pointer 0; req0 re-requests after its grant.
    log_q.delete();
    issue(0, 32'd10, 32'd8, 5'd1);
    issue(1, 32'd10, 32'd8, 5'd2);
    issue(2, 32'd10, 32'd8, 5'd3);
    issue(3, 32'd10, 32'd8, 5'd4);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      step();
      if (!pend_v[0]) seen = 1'b1;
    end
    if (!seen) bound_fail("all4_grant0");
    issue(0, 32'd3, 32'd4, 5'd0);
    drain("all4");
    chk("all4_count", 64'(log_q.size()), 64'd5);
    for (int i = 0; i < 5 && i < log_q.size(); i++) begin
      chk("all4_id", 64'(log_q[i].id), 64'(exp_ids4[i]));
      chk("all4_data", 64'(log_q[i].data), 64'(exp_dat4[i]));
    end

    // Backpressure: response held while resp_ready stays low.
    rr_mode    = 0;
    resp_ready = 1'b0;
    issue(1, 32'd5, 32'd6, 5'd0);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      step();
      if (resp_valid) seen = 1'b1;
    end
    if (!seen) bound_fail("bp_resp_valid");
    issue(3, 32'd7, 32'd7, 5'd2);
    repeat (5) begin
      step();
      chk("bp_data", 64'(resp_data), 64'd11);
      chk("bp_id", 64'(resp_id), 64'd1);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_busy", 64'(busy), 64'd1);
    end
    rr_mode    = 1;
    resp_ready = 1'b1;
    step();
    chk("bp_release_idle", 64'(busy), 64'd0);
    drain("bp");

    // Illegal opcode then a legal signed compare, both from req2.
    log_q.delete();
    issue(2, 32'd10, 32'd8, 5'b10101);
    drain("illegal");
    issue(2, 32'd10, 32'd8, 5'b01010);
    drain("lt");
    chk("ill_count", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      chk("ill_err", 64'(log_q[0].err), 64'd1);
      chk("ill_data", 64'(log_q[0].data), 64'd0);
      chk("ill_id", 64'(log_q[0].id), 64'd2);
      chk("lt_err", 64'(log_q[1].err), 64'd0);
      chk("lt_data", 64'(log_q[1].data), 64'd0);
    end

    // Pointer now 3: req3 must beat req1, then wrap to req1.
    log_q.delete();
    issue(1, 32'd1, 32'd1, 5'd0);
    issue(3, 32'd2, 32'd2, 5'd0);
    drain("wrap");
    chk("wrap_count", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      chk("wrap_first", 64'(log_q[0].id), 64'd3);
      chk("wrap_second", 64'(log_q[1].id), 64'd1);
    end

    // Random traffic, random backpressure, occasional withdrawn requests.
    rr_mode = 2;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend_v[i]) begin
          if ($urandom_range(0, 2) == 0)
            issue(i, $urandom, $urandom, 5'($urandom_range(0, 31)));
        end else if ($urandom_range(0, 15) == 0) begin
          pend_v[i] = 1'b0;
        end
      end
      apply();
      step();
    end
    rr_mode = 1;
    drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU (32-bit operands, 5-bit opcode) among NREQ requesters using round-robin arbitration.
- Each requester issues one operation with a valid/ready handshake and gets back a tagged result with valid/ready backpressure.
- Sits between the multi-cycle processor's requesting units (execute, address generation, branch compare) and the ALU instance.
- The ALU itself stays outside this block, connected through the alu_* ports.

Parameters:
- DATA_W, 32, operand and result width.
- OP_W, 5, opcode width.
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester tag; must satisfy 2^ID_W >= NREQ.
- MAX_OP, 5'b10000, highest legal opcode (MVHI); above this is illegal.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_src1  in  NREQ*DATA_W  flattened operand 1; requester i occupies bits [i*DATA_W +: DATA_W].
- req_src2  in  NREQ*DATA_W  flattened operand 2, same packing.
- req_op  in  NREQ*OP_W  flattened opcodes, same packing.
- alu_src1  out  DATA_W  registered operand 1 to the ALU.
- alu_src2  out  DATA_W  registered operand 2 to the ALU.
- alu_op  out  OP_W  registered opcode to the ALU.
- alu_result  in  DATA_W  combinational ALU data_out.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  ID_W  index of the requester owning the result.
- resp_data  out  DATA_W  captured result.
- resp_err  out  1  set when the opcode was illegal.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE; round-robin pointer = 0.
  - alu_src1, alu_src2 = 0; alu_op = 0.
  - resp_valid, resp_err = 0; resp_id = 0; resp_data = 0; req_ready = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Combinationally picks the first i with req_valid[i]=1, scanning from pointer, pointer+1, … modulo NREQ.
  - Asserts req_ready[i] in that same cycle. The handshake completes on that edge.
  - On that edge: latches src1, src2 and op into alu_*; latches i as tag; sets pointer = (i+1) mod NREQ; goes to EXEC.
  - No valid requests: stays in IDLE; all outputs hold.
- EXEC (exactly one cycle):
  - Captures resp_data = alu_result and resp_id = tag; sets resp_valid = 1; goes to RESP.
  - If the latched op > MAX_OP: resp_data = 0 and resp_err = 1, and alu_result is ignored.
  - Otherwise resp_err = 0.
- RESP:
  - Holds resp_valid, resp_id, resp_data and resp_err stable until resp_valid && resp_ready at a rising edge.
  - On that edge: clears resp_valid and returns to IDLE.
  - req_ready = 0 throughout EXEC and RESP; no new grant until back in IDLE.
- Latency and throughput:
  - Request accepted at edge T; resp_valid high from T+2 at the earliest.
  - One operation is outstanding at most; peak throughput is one op per 3 cycles when resp_ready is held high.
- alu_* outputs hold their last values outside EXEC; they are not cleared after use.
- Requester-side rule: a requester must hold valid, src1, src2 and op stable until it sees req_ready. Dropping valid before grant is allowed, and such a requester is simply skipped.
- Simultaneous requests: exactly one grant per IDLE cycle. The pointer guarantees each requester is granted within NREQ operations.
- Pointer wrap: after granting NREQ-1, pointer = 0.
- resp_ready high while in IDLE or EXEC has no effect.
- Reset asserted mid-operation: FSM returns to IDLE at once. The in-flight result is discarded, with no response emitted after release; the pointer returns to 0.
- No combinational path from resp_ready to req_ready.

Test Plan:
- Single request, req0 src1=10 src2=8 op=00000, resp_ready=1 -> req_ready[0] pulses one cycle; two cycles later resp_valid=1, resp_data=18, resp_id=0, resp_err=0.
- All four requesters valid at once, ops SUB/AND/OR/XOR on 10,8 -> grants in order 0,1,2,3; results 2, 8, 10, 2 with ids 0..3; then req0 again wins only after req3.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid -> resp_data and resp_id stable, req_ready stays 0, busy=1; raise resp_ready -> FSM back in IDLE next cycle.
- Illegal op 5'b10101 from req2 -> resp_valid with resp_err=1, resp_data=0, resp_id=2; the next legal op 01010 (LT, 10<8) returns resp_data=0 with resp_err=0.
- Pointer wrap: pointer at 3, only req1 and req3 valid -> req3 granted first, then req1.
- rst_n pulsed low while in EXEC -> all outputs at reset values immediately; no resp_valid after release until a new request is accepted.
